// File: rtl/vpu_obj_pkg.sv
// Object word layout and scan FSM types for the video object pipeline.
// The same layout is used by the object memory and by every reader of it.
package vpu_obj_pkg;

  localparam int OBJ_W     = 144;
  localparam int COORD_W   = 16;
  localparam int X0_LSB    = 0;
  localparam int Y0_LSB    = 16;
  localparam int X1_LSB    = 32;
  localparam int Y1_LSB    = 48;
  localparam int X2_LSB    = 64;
  localparam int Y2_LSB    = 80;
  localparam int X3_LSB    = 96;
  localparam int Y3_LSB    = 112;
  localparam int COLOR_LSB = 128;
  localparam int COLOR_W   = 12;
  localparam int TYPE_LSB  = 140;
  localparam int TYPE_W    = 4;

  localparam logic [TYPE_W-1:0] OBJ_TYPE_NONE = 4'd0;

  typedef struct packed {
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic [COORD_W-1:0] x2;
    logic [COORD_W-1:0] y2;
    logic [COORD_W-1:0] x3;
    logic [COORD_W-1:0] y3;
    logic [COLOR_W-1:0] color;
    logic [TYPE_W-1:0]  obj_type;
  } obj_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_EMIT,
    ST_DONE
  } fetch_state_t;

  function automatic obj_t unpack_obj(input logic [OBJ_W-1:0] w);
    obj_t o;
    o.x0       = w[X0_LSB    +: COORD_W];
    o.y0       = w[Y0_LSB    +: COORD_W];
    o.x1       = w[X1_LSB    +: COORD_W];
    o.y1       = w[Y1_LSB    +: COORD_W];
    o.x2       = w[X2_LSB    +: COORD_W];
    o.y2       = w[Y2_LSB    +: COORD_W];
    o.x3       = w[X3_LSB    +: COORD_W];
    o.y3       = w[Y3_LSB    +: COORD_W];
    o.color    = w[COLOR_LSB +: COLOR_W];
    o.obj_type = w[TYPE_LSB  +: TYPE_W];
    return o;
  endfunction

endpackage

// File: rtl/clip_fetch_unit_if.sv
// Unpacked-object stream from the clip fetch unit to the clipping/raster stage.
interface clip_fetch_unit_if #(
  parameter int ADDR_W = 5
);
  logic                                obj_valid;
  logic                                obj_ready;
  logic [vpu_obj_pkg::COORD_W-1:0]     x0, y0, x1, y1, x2, y2, x3, y3;
  logic [vpu_obj_pkg::COLOR_W-1:0]     color;
  logic [vpu_obj_pkg::TYPE_W-1:0]      obj_type;
  logic [ADDR_W-1:0]                   obj_idx;

  modport master (
    output obj_valid, x0, y0, x1, y1, x2, y2, x3, y3, color, obj_type, obj_idx,
    input  obj_ready
  );

  modport slave (
    input  obj_valid, x0, y0, x1, y1, x2, y2, x3, y3, color, obj_type, obj_idx,
    output obj_ready
  );
endinterface

// File: rtl/clip_fetch_unit.sv
// Scans the object memory once per start, skips empty entries and streams
// each live object downstream on a valid/ready handshake.
module clip_fetch_unit
  import vpu_obj_pkg::*;
#(
  parameter int NUM_ENTRIES = 32,
  parameter int ADDR_W      = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [ADDR_W-1:0]   clip_addr,
  output logic                clip_rd_en,
  input  logic [OBJ_W-1:0]    clip_obj_in,
  clip_fetch_unit_if.master   obj,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     obj_count
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W:0]   count_q;
  obj_t              obj_q;
  logic              last_entry;
  logic              live_in;
  logic              xfer;

  assign last_entry = (cnt_q == ADDR_W'(NUM_ENTRIES - 1));
  assign live_in    = (clip_obj_in[TYPE_LSB +: TYPE_W] != OBJ_TYPE_NONE);
  assign xfer       = (state_q == ST_EMIT) && obj.obj_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RD;
      ST_RD:   state_d = ST_CAP;
      ST_CAP: begin
        if (live_in)         state_d = ST_EMIT;
        else if (last_entry) state_d = ST_DONE;
        else                 state_d = ST_RD;
      end
      ST_EMIT: if (xfer) state_d = last_entry ? ST_DONE : ST_RD;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      count_q <= '0;
      obj_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cnt_q   <= '0;
            count_q <= '0;
          end
        end
        ST_CAP: begin
          if (live_in) begin
            obj_q <= unpack_obj(clip_obj_in);
            idx_q <= cnt_q;
          end else if (!last_entry) begin
            cnt_q <= cnt_q + ADDR_W'(1);
          end
        end
        ST_EMIT: begin
          // Counter stops at the last entry so it never wraps within a scan.
          if (xfer) begin
            count_q <= count_q + (ADDR_W + 1)'(1);
            if (!last_entry) cnt_q <= cnt_q + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // All outputs decode from registers; obj_ready only steers the next state.
  assign clip_rd_en    = (state_q == ST_RD);
  assign clip_addr     = cnt_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign obj_count     = count_q;

  assign obj.obj_valid = (state_q == ST_EMIT);
  assign obj.x0        = obj_q.x0;
  assign obj.y0        = obj_q.y0;
  assign obj.x1        = obj_q.x1;
  assign obj.y1        = obj_q.y1;
  assign obj.x2        = obj_q.x2;
  assign obj.y2        = obj_q.y2;
  assign obj.x3        = obj_q.x3;
  assign obj.y3        = obj_q.y3;
  assign obj.color     = obj_q.color;
  assign obj.obj_type  = obj_q.obj_type;
  assign obj.obj_idx   = idx_q;

endmodule

// File: tb/tb_clip_fetch_unit.sv
// Directed bench for clip_fetch_unit with a registered-read object memory model.
module tb_clip_fetch_unit;
  import vpu_obj_pkg::*;

  localparam int NUM_ENTRIES = 32;
  localparam int ADDR_W      = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] clip_addr;
  logic              clip_rd_en;
  logic [OBJ_W-1:0]  clip_obj_in;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   obj_count;

  clip_fetch_unit_if #(.ADDR_W(ADDR_W)) obj ();

  clip_fetch_unit #(.NUM_ENTRIES(NUM_ENTRIES), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .clip_addr   (clip_addr),
    .clip_rd_en  (clip_rd_en),
    .clip_obj_in (clip_obj_in),
    .obj         (obj),
    .busy        (busy),
    .done        (done),
    .obj_count   (obj_count)
  );

  always #5 clk = ~clk;

  logic [OBJ_W-1:0] mem [NUM_ENTRIES];
  always @(posedge clk) if (clip_rd_en) clip_obj_in <= mem[clip_addr];

  logic [OBJ_W-1:0] bus_w;
  assign bus_w = {obj.obj_type, obj.color, obj.y3, obj.x3, obj.y2, obj.x2,
                  obj.y1, obj.x1, obj.y0, obj.x0};

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int               acc_idx[$];
  logic [OBJ_W-1:0] acc_word[$];
  int               acc_k[$];
  int               rd_addr[$];
  int valid_cyc, unstable, rd_during_valid, done_pulses, post_bad;

  function automatic logic [OBJ_W-1:0] make_obj(input int idx, input logic [3:0] t,
                                                input logic [11:0] c);
    logic [127:0] v;
    for (int i = 0; i < 8; i++) v[i*16 +: 16] = 16'(idx * 256 + i * 17 + 1);
    return {t, c, v};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < NUM_ENTRIES; i++) mem[i] = '0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // k = 0 is the negedge inside the RD cycle of entry 0.
  task automatic scan(input int stall_n, input int mid_k, input bit start_in_done,
                      output int done_cyc);
    int stall_left;
    bit fresh;
    logic [OBJ_W+ADDR_W-1:0] ref_w;
    acc_idx.delete(); acc_word.delete(); acc_k.delete(); rd_addr.delete();
    valid_cyc = 0; unstable = 0; rd_during_valid = 0; done_pulses = 0; post_bad = 0;
    done_cyc = -1; stall_left = stall_n; fresh = 1'b1; ref_w = '0;
    obj.obj_ready = (stall_n == 0);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      start = (mid_k >= 0) && (k == mid_k);
      if (clip_rd_en) rd_addr.push_back(int'(clip_addr));
      if (done) begin
        done_cyc = k;
        done_pulses++;
        break;
      end
      if (obj.obj_valid) begin
        valid_cyc++;
        if (clip_rd_en) rd_during_valid++;
        if (fresh) begin
          ref_w = {obj.obj_idx, bus_w};
          fresh = 1'b0;
        end else if ({obj.obj_idx, bus_w} !== ref_w) begin
          unstable++;
        end
        if (stall_left > 0) begin
          obj.obj_ready = 1'b0;
          stall_left--;
        end else begin
          obj.obj_ready = 1'b1;
          acc_idx.push_back(int'(obj.obj_idx));
          acc_word.push_back(bus_w);
          acc_k.push_back(k);
          fresh = 1'b1;
        end
      end
    end
    start = start_in_done && (done_cyc >= 0);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy || done) post_bad++;
    end
  endtask

  function automatic int words_bad();
    int bad = 0;
    for (int i = 0; i < acc_idx.size(); i++)
      if (acc_word[i] !== mem[acc_idx[i]]) bad++;
    return bad;
  endfunction

  function automatic int addr_order_bad();
    int bad = 0;
    for (int i = 0; i < rd_addr.size(); i++) if (rd_addr[i] != i) bad++;
    return bad;
  endfunction

  function automatic int q_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  initial begin
    int dc;
    int seen;
    logic [OBJ_W-1:0] w;

    rst = 1'b1; start = 1'b0; obj.obj_ready = 1'b0;
    clear_mem();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_en", clip_rd_en, 0);
    check("rst_valid", obj.obj_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", clip_addr, 0);
    check("rst_count", obj_count, 0);
    check("rst_idx", obj.obj_idx, 0);
    check("rst_fields", (bus_w == '0), 1);
    rst = 1'b0;

    // Empty frame
    pulse_start();
    scan(0, -1, 1'b0, dc);
    check("empty_done_cyc", dc, 64);
    check("empty_valid_cyc", valid_cyc, 0);
    check("empty_count", obj_count, 0);
    check("empty_rd_n", rd_addr.size(), 32);
    check("empty_addr_order", addr_order_bad(), 0);
    check("empty_post", post_bad, 0);

    // Entries 0, 7, 31 live
    clear_mem();
    mem[0]  = make_obj(0, 4'h1, 12'h111);
    mem[7]  = make_obj(7, 4'h2, 12'hABC);
    mem[7][15:0]    = 16'h0010;
    mem[7][127:112] = 16'hFFF0;
    mem[31] = make_obj(31, 4'hF, 12'hFFF);
    pulse_start();
    scan(0, -1, 1'b0, dc);
    check("three_n", acc_idx.size(), 3);
    check("three_idx0", q_at(acc_idx, 0), 0);
    check("three_idx1", q_at(acc_idx, 1), 7);
    check("three_idx2", q_at(acc_idx, 2), 31);
    w = (acc_word.size() > 1) ? acc_word[1] : '0;
    check("e7_x0", w[15:0], 16'h0010);
    check("e7_y3", w[127:112], 16'hFFF0);
    check("e7_color", w[139:128], 12'hABC);
    check("e7_type", w[143:140], 4'h2);
    check("three_words", words_bad(), 0);
    check("three_count", obj_count, 3);
    check("three_done_cyc", dc, 67);
    check("three_done_after_31", dc - q_at(acc_k, 2), 1);

    // Same frame with start mid-scan and in the DONE cycle
    pulse_start();
    scan(0, 10, 1'b1, dc);
    check("restart_done_cyc", dc, 67);
    check("restart_n", acc_idx.size(), 3);
    check("restart_idx1", q_at(acc_idx, 1), 7);
    check("restart_idx2", q_at(acc_idx, 2), 31);
    check("restart_done_pulses", done_pulses, 1);
    check("restart_post", post_bad, 0);

    // Entry 3 live with a 5-cycle stall
    clear_mem();
    mem[3] = make_obj(3, 4'h5, 12'h123);
    pulse_start();
    scan(5, -1, 1'b0, dc);
    check("stall_valid_cyc", valid_cyc, 6);
    check("stall_n", acc_idx.size(), 1);
    check("stall_idx", q_at(acc_idx, 0), 3);
    check("stall_stable", unstable, 0);
    check("stall_rd_quiet", rd_during_valid, 0);
    check("stall_words", words_bad(), 0);
    check("stall_done_cyc", dc, 70);
    check("stall_count", obj_count, 1);

    // Reset while entry 5 is pending
    clear_mem();
    mem[0] = make_obj(0, 4'h1, 12'h0F0);
    mem[5] = make_obj(5, 4'h6, 12'h555);
    obj.obj_ready = 1'b1;
    pulse_start();
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (obj.obj_valid && obj.obj_idx == 5'd5) begin
        seen = 1;
        break;
      end
    end
    check("rst5_seen", seen, 1);
    check("rst5_count_before", obj_count, 1);
    obj.obj_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rst5_valid", obj.obj_valid, 0);
    check("rst5_busy", busy, 0);
    check("rst5_count", obj_count, 0);
    check("rst5_done", done, 0);
    rst = 1'b0;
    pulse_start();
    scan(0, -1, 1'b0, dc);
    check("rescan_n", acc_idx.size(), 2);
    check("rescan_idx0", q_at(acc_idx, 0), 0);
    check("rescan_idx1", q_at(acc_idx, 1), 5);
    check("rescan_done_cyc", dc, 66);
    check("rescan_count", obj_count, 2);

    // All entries live
    for (int i = 0; i < NUM_ENTRIES; i++) mem[i] = make_obj(i, 4'(i % 15 + 1), 12'(i * 3));
    pulse_start();
    scan(0, -1, 1'b0, dc);
    check("full_n", acc_idx.size(), 32);
    check("full_count", obj_count, 6'b100000);
    check("full_done_cyc", dc, 96);
    check("full_last_idx", q_at(acc_idx, 31), 31);
    check("full_words", words_bad(), 0);
    check("full_rd_n", rd_addr.size(), 32);
    check("full_addr_order", addr_order_bad(), 0);
    check("full_post", post_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
